fft_peak_detect: RTL

Spectrum peak finder directly downstream of the FFT core that the FIFO-to-FFT sequencer starts once per 1024-point frame. Consumes the FFT's streamed complex output bins and computes |X[k]|² per bin through a 3-stage pipeline. Tracks the largest magnitude within a configurable bin window and reports the winning bin index and magnitude once per complete frame. Malformed frames are flagged and discarded.

---
 rtl/fft_peak_detect.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/fft_peak_detect.sv
// fft_peak_detect: finds the largest |X[k]|^2 inside [SEARCH_LO, SEARCH_HI]
// over one streamed FFT frame and reports its bin index and magnitude.
// Optional feature macro: PEAK_THRESH_EN (adds peak_thresh; report only if max > thresh).
module fft_peak_detect #(
  parameter int TRANSFORM_LEN = 1024,
  parameter int DATA_W        = 16,
  parameter int IDX_W         = 10,
  parameter int SEARCH_LO     = 1,
  parameter int SEARCH_HI     = 511
) (
  input  logic                  clk_50m,
  input  logic                  rst,
  input  logic                  fft_valid,
  input  logic                  fft_sop,
  input  logic                  fft_eop,
  input  logic [DATA_W-1:0]     fft_re,
  input  logic [DATA_W-1:0]     fft_im,
`ifdef PEAK_THRESH_EN
  input  logic [2*DATA_W-1:0]   peak_thresh,
`endif
  output logic                  peak_valid,
  output logic [IDX_W-1:0]      peak_idx,
  output logic [2*DATA_W-1:0]   peak_mag,
  output logic                  frame_err,
  output logic                  busy
);
  localparam int MAG_W  = 2*DATA_W;
  localparam int STAGES = 2;  // pipe index 0..2 = stage 1..3
  localparam logic [IDX_W-1:0] LO_IDX   = IDX_W'(SEARCH_LO);
  localparam logic [IDX_W-1:0] HI_IDX   = IDX_W'(SEARCH_HI);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TRANSFORM_LEN-1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCUM  = 2'd1;
  localparam logic [1:0] S_FLUSH  = 2'd2;
  localparam logic [1:0] S_REPORT = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             frame_err_q, frame_err_d;

  // per-bin sideband carried alongside the datapath
  logic [STAGES:0]             vld_pipe, sop_pipe, last_pipe;
  logic [STAGES:0][IDX_W-1:0]  idx_pipe;

  logic signed [DATA_W-1:0] re1_q, im1_q;
  logic signed [MAG_W-1:0]  re2sq_q, im2sq_q;
  logic [MAG_W-1:0]         mag3_q;

  logic [MAG_W-1:0] max_mag_q, max_mag_d, base_mag;
  logic [IDX_W-1:0] max_idx_q, max_idx_d, base_idx;

  logic             peak_valid_q, peak_valid_d;
  logic [IDX_W-1:0] peak_idx_q, peak_idx_d;
  logic [MAG_W-1:0] peak_mag_q, peak_mag_d;

  logic             acc, acc_sop, acc_last, fire;
  logic [IDX_W-1:0] acc_idx;

  // frame FSM: decides which input bins enter the pipeline and flags malformed frames
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    frame_err_d = 1'b0;
    acc         = 1'b0;
    acc_sop     = 1'b0;
    acc_last    = 1'b0;
    acc_idx     = cnt_q;
    case (state_q)
      S_IDLE: if (fft_valid && fft_sop) begin
        acc = 1'b1; acc_sop = 1'b1; acc_idx = '0;
        cnt_d = IDX_W'(1); state_d = S_ACCUM;
      end
      S_ACCUM: if (fft_valid) begin
        if (fft_sop) begin
          // restart: old frame is dropped, this bin becomes bin 0
          frame_err_d = 1'b1;
          acc = 1'b1; acc_sop = 1'b1; acc_idx = '0;
          cnt_d = IDX_W'(1);
        end else if (fft_eop && cnt_q != LAST_IDX) begin
          frame_err_d = 1'b1;
          state_d     = S_IDLE;
        end else begin
          acc   = 1'b1;
          cnt_d = cnt_q + IDX_W'(1);
          if (cnt_q == LAST_IDX) begin
            acc_last = 1'b1;
            state_d  = S_FLUSH;
          end
        end
      end
      S_FLUSH: if (vld_pipe[STAGES] && last_pipe[STAGES]) state_d = S_REPORT;
      default: state_d = S_IDLE;  // S_REPORT
    endcase
  end

  // running maximum; a frame's first bin reaching the compare resets the baseline
  always_comb begin
    base_mag  = sop_pipe[STAGES] ? '0     : max_mag_q;
    base_idx  = sop_pipe[STAGES] ? LO_IDX : max_idx_q;
    max_mag_d = max_mag_q;
    max_idx_d = max_idx_q;
    if (vld_pipe[STAGES]) begin
      max_mag_d = base_mag;
      max_idx_d = base_idx;
      if (idx_pipe[STAGES] >= LO_IDX && idx_pipe[STAGES] <= HI_IDX && mag3_q > base_mag) begin
        max_mag_d = mag3_q;
        max_idx_d = idx_pipe[STAGES];
      end
    end
  end

  // report stage: publish the frame maximum, optionally gated by threshold
  always_comb begin
`ifdef PEAK_THRESH_EN
    fire = (state_q == S_REPORT) && (max_mag_q > peak_thresh);
`else
    fire = (state_q == S_REPORT);
`endif
    peak_valid_d = fire;
    peak_idx_d   = fire ? max_idx_q : peak_idx_q;
    peak_mag_d   = fire ? max_mag_q : peak_mag_q;
  end

  // control and output registers
  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      frame_err_q  <= 1'b0;
      max_mag_q    <= '0;
      max_idx_q    <= LO_IDX;
      peak_valid_q <= 1'b0;
      peak_idx_q   <= '0;
      peak_mag_q   <= '0;
      vld_pipe     <= '0;
      sop_pipe     <= '0;
      last_pipe    <= '0;
      idx_pipe     <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      frame_err_q  <= frame_err_d;
      max_mag_q    <= max_mag_d;
      max_idx_q    <= max_idx_d;
      peak_valid_q <= peak_valid_d;
      peak_idx_q   <= peak_idx_d;
      peak_mag_q   <= peak_mag_d;
      vld_pipe     <= {vld_pipe[STAGES-1:0], acc};
      sop_pipe     <= {sop_pipe[STAGES-1:0], acc_sop};
      last_pipe    <= {last_pipe[STAGES-1:0], acc_last};
      idx_pipe     <= {idx_pipe[STAGES-1:0], acc_idx};
    end
  end

  // magnitude datapath: register, square, sum
  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      re1_q   <= '0;
      im1_q   <= '0;
      re2sq_q <= '0;
      im2sq_q <= '0;
      mag3_q  <= '0;
    end else begin
      re1_q   <= fft_re;
      im1_q   <= fft_im;
      re2sq_q <= re1_q * re1_q;
      im2sq_q <= im1_q * im1_q;
      mag3_q  <= $unsigned(re2sq_q) + $unsigned(im2sq_q);
    end
  end

  assign peak_valid = peak_valid_q;
  assign peak_idx   = peak_idx_q;
  assign peak_mag   = peak_mag_q;
  assign frame_err  = frame_err_q;
  assign busy       = (state_q != S_IDLE);
endmodule
